// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with writeback forwarding between decode and execute.
module operand_fetch #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int PAYLOAD_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [PAYLOAD_W-1:0]  in_payload,
  output logic [REG_ADDR_W-1:0] rf_addr_a,
  output logic [REG_ADDR_W-1:0] rf_addr_b,
  input  logic [XLEN-1:0]       rf_data_a,
  input  logic [XLEN-1:0]       rf_data_b,
  input  logic                  wb_en,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [XLEN-1:0]       out_op_a,
  output logic [XLEN-1:0]       out_op_b,
  output logic [PAYLOAD_W-1:0]  out_payload
);
  logic                  r_valid_q, r_valid_d, out_valid_q, out_valid_d;
  logic [REG_ADDR_W-1:0] r_rs1_q, r_rs1_d, r_rs2_q, r_rs2_d;
  logic [REG_ADDR_W-1:0] out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
  logic [PAYLOAD_W-1:0]  r_payload_q, r_payload_d, out_payload_q, out_payload_d;
  logic                  fwd_a_hit_q, fwd_a_hit_d, fwd_b_hit_q, fwd_b_hit_d;
  logic [XLEN-1:0]       fwd_a_data_q, fwd_a_data_d, fwd_b_data_q, fwd_b_data_d;
  logic [XLEN-1:0]       out_op_a_q, out_op_a_d, out_op_b_q, out_op_b_d;
  logic [XLEN-1:0]       r_op_a, r_op_b;
  logic                  o_free, r_adv, held, accept;
  function automatic logic wb_hit(input logic [REG_ADDR_W-1:0] x);
    return wb_en && (wb_addr != '0) && (wb_addr == x);
  endfunction
  assign o_free    = !out_valid_q || out_ready;
  assign r_adv     = r_valid_q && o_free;
  assign held      = out_valid_q && !out_ready;
  assign in_ready  = rst_n && !flush && (!r_valid_q || r_adv);
  assign accept    = in_valid && in_ready;
  // a stalled R stage keeps re-reading its own sources so late writebacks are seen
  assign rf_addr_a = (r_valid_q && !r_adv) ? r_rs1_q : in_rs1;
  assign rf_addr_b = (r_valid_q && !r_adv) ? r_rs2_q : in_rs2;
  assign r_op_a    = (r_rs1_q == '0) ? '0 : fwd_a_hit_q ? fwd_a_data_q : rf_data_a;
  assign r_op_b    = (r_rs2_q == '0) ? '0 : fwd_b_hit_q ? fwd_b_data_q : rf_data_b;
  always_comb begin
    r_valid_d     = flush ? 1'b0 : accept ? 1'b1 : r_adv ? 1'b0 : r_valid_q;
    r_rs1_d       = accept ? in_rs1 : r_rs1_q;
    r_rs2_d       = accept ? in_rs2 : r_rs2_q;
    r_payload_d   = accept ? in_payload : r_payload_q;
    fwd_a_hit_d   = wb_hit(rf_addr_a);
    fwd_b_hit_d   = wb_hit(rf_addr_b);
    fwd_a_data_d  = wb_data;
    fwd_b_data_d  = wb_data;
    out_valid_d   = flush ? 1'b0 : r_adv ? 1'b1 : held;
    out_rs1_d     = r_adv ? r_rs1_q : out_rs1_q;
    out_rs2_d     = r_adv ? r_rs2_q : out_rs2_q;
    out_payload_d = r_adv ? r_payload_q : out_payload_q;
    out_op_a_d    = r_adv ? (wb_hit(r_rs1_q) ? wb_data : r_op_a)
                  : (held && wb_hit(out_rs1_q)) ? wb_data : out_op_a_q;
    out_op_b_d    = r_adv ? (wb_hit(r_rs2_q) ? wb_data : r_op_b)
                  : (held && wb_hit(out_rs2_q)) ? wb_data : out_op_b_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid_q     <= 1'b0;
      r_rs1_q       <= '0;
      r_rs2_q       <= '0;
      r_payload_q   <= '0;
      fwd_a_hit_q   <= 1'b0;
      fwd_b_hit_q   <= 1'b0;
      fwd_a_data_q  <= '0;
      fwd_b_data_q  <= '0;
      out_valid_q   <= 1'b0;
      out_rs1_q     <= '0;
      out_rs2_q     <= '0;
      out_payload_q <= '0;
      out_op_a_q    <= '0;
      out_op_b_q    <= '0;
    end else begin
      r_valid_q     <= r_valid_d;
      r_rs1_q       <= r_rs1_d;
      r_rs2_q       <= r_rs2_d;
      r_payload_q   <= r_payload_d;
      fwd_a_hit_q   <= fwd_a_hit_d;
      fwd_b_hit_q   <= fwd_b_hit_d;
      fwd_a_data_q  <= fwd_a_data_d;
      fwd_b_data_q  <= fwd_b_data_d;
      out_valid_q   <= out_valid_d;
      out_rs1_q     <= out_rs1_d;
      out_rs2_q     <= out_rs2_d;
      out_payload_q <= out_payload_d;
      out_op_a_q    <= out_op_a_d;
      out_op_b_q    <= out_op_b_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_rs1     = out_rs1_q;
  assign out_rs2     = out_rs2_q;
  assign out_op_a    = out_op_a_q;
  assign out_op_b    = out_op_b_q;
  assign out_payload = out_payload_q;
endmodule
